rtc_fecha_reader: RTL

- Reads the RTC date registers (day 0x24, month 0x25, year 0x26) over the multiplexed AD bus (ad/wr/rd/cs).
- Uses the same bus timing as the date-write sequencer.
- Each read is an address-write phase followed by a rd-strobed data phase with the bus released.
- The three bytes are captured into shadow registers and presented together to the display/control logic.

---
 rtl/rtc_fecha_reader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_fecha_reader.sv
// Reads the RTC date registers (day 0x24, month 0x25, year 0x26) over the multiplexed AD bus.
// Optional macro BCD_CHECK_EN adds the err output and BCD/range validation at commit.
module rtc_fecha_reader #(
    parameter int unsigned STROBE = 5,
    parameter int unsigned GAP    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chs,
    input  logic [7:0] ADin,
    output logic [7:0] ADout,
    output logic       bus_oe,
    output logic       ad,
    output logic       wr,
    output logic       rd,
    output logic       cs,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] year,
    output logic       busy,
`ifdef BCD_CHECK_EN
    output logic       err,
`endif
    output logic       valid
);

    localparam int unsigned CW    = 6;
    localparam int unsigned A_POS = 13 + GAP;
    localparam int unsigned L_LEN = A_POS + STROBE + 6;

    localparam logic [CW-1:0] C_AD_LO  = CW'(1);
    localparam logic [CW-1:0] C_AD_HI  = CW'(5 + STROBE);
    localparam logic [CW-1:0] C_CS1_LO = CW'(2);
    localparam logic [CW-1:0] C_CS1_HI = CW'(4 + STROBE);
    localparam logic [CW-1:0] C_OE_LO  = CW'(3);
    localparam logic [CW-1:0] C_OE_HI  = CW'(12);
    localparam logic [CW-1:0] C_WR_LO  = CW'(4);
    localparam logic [CW-1:0] C_WR_HI  = CW'(3 + STROBE);
    localparam logic [CW-1:0] C_CS2_LO = CW'(A_POS);
    localparam logic [CW-1:0] C_CS2_HI = CW'(A_POS + 1 + STROBE);
    localparam logic [CW-1:0] C_RD_LO  = CW'(A_POS + 1);
    localparam logic [CW-1:0] C_RD_HI  = CW'(A_POS + STROBE);
    localparam logic [CW-1:0] C_CAP    = CW'(A_POS + STROBE);
    localparam logic [CW-1:0] C_LAST   = CW'(L_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [1:0]    idx_q, idx_d;
    logic          chs_q, chs_d;
    logic [7:0]    day_sh_q, day_sh_d;
    logic [7:0]    mon_sh_q, mon_sh_d;
    logic [7:0]    yr_sh_q, yr_sh_d;
    logic [7:0]    dia_q, dia_d;
    logic [7:0]    mes_q, mes_d;
    logic [7:0]    year_q, year_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [7:0]    adout_q, adout_d;
    logic          oe_q, oe_d;
    logic          ad_q, ad_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          cs_q, cs_d;
`ifdef BCD_CHECK_EN
    logic          err_q, err_d;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction
`endif

    // Sequencer: start detect, transaction counter, capture and commit.
    always_comb begin
        state_d  = state_q;
        cont_d   = cont_q;
        idx_d    = idx_q;
        chs_d    = chs;
        day_sh_d = day_sh_q;
        mon_sh_d = mon_sh_q;
        yr_sh_d  = yr_sh_q;
        dia_d    = dia_q;
        mes_d    = mes_q;
        year_d   = year_q;
        valid_d  = 1'b0;
`ifdef BCD_CHECK_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (chs && !chs_q) begin
                    state_d = S_RUN;
                    cont_d  = '0;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                // Data is taken on the edge that releases rd.
                if (cont_q == C_CAP) begin
                    unique case (idx_q)
                        2'd0:    day_sh_d = ADin;
                        2'd1:    mon_sh_d = ADin;
                        default: yr_sh_d  = ADin;
                    endcase
                end
                if (cont_q == C_LAST) begin
                    cont_d = '0;
                    if (idx_q == 2'd2) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d = 2'(idx_q + 2'd1);
                    end
                end else begin
                    cont_d = CW'(cont_q + CW'(1));
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
`ifdef BCD_CHECK_EN
                if (bcd_ok(day_sh_q, 8'h01, 8'h31) && bcd_ok(mon_sh_q, 8'h01, 8'h12) &&
                    bcd_ok(yr_sh_q, 8'h00, 8'h99)) begin
                    dia_d   = day_sh_q;
                    mes_d   = mon_sh_q;
                    year_d  = yr_sh_q;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d   = 1'b1;
                end
`else
                dia_d   = day_sh_q;
                mes_d   = mon_sh_q;
                year_d  = yr_sh_q;
                valid_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the next counter value so the flops show the phase of cont.
    always_comb begin
        ad_d    = 1'b1;
        wr_d    = 1'b1;
        rd_d    = 1'b1;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        adout_d = 8'hFF;
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_RUN) begin
            ad_d = !((cont_d >= C_AD_LO) && (cont_d <= C_AD_HI));
            cs_d = !(((cont_d >= C_CS1_LO) && (cont_d <= C_CS1_HI)) ||
                     ((cont_d >= C_CS2_LO) && (cont_d <= C_CS2_HI)));
            // wr falls together with the address so the pulse is STROBE clocks wide.
            wr_d = !((cont_d >= C_WR_LO) && (cont_d <= C_WR_HI));
            rd_d = !((cont_d >= C_RD_LO) && (cont_d <= C_RD_HI));
            oe_d = (cont_d >= C_OE_LO) && (cont_d <= C_OE_HI);
            if ((cont_d >= C_WR_LO) && (cont_d <= C_OE_HI)) begin
                adout_d = 8'(8'h24 + 8'(idx_d));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cont_q   <= '0;
            idx_q    <= '0;
            chs_q    <= 1'b0;
            day_sh_q <= '0;
            mon_sh_q <= '0;
            yr_sh_q  <= '0;
            dia_q    <= '0;
            mes_q    <= '0;
            year_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            adout_q  <= 8'hFF;
            oe_q     <= 1'b0;
            ad_q     <= 1'b1;
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            cs_q     <= 1'b1;
`ifdef BCD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_d;
            idx_q    <= idx_d;
            chs_q    <= chs_d;
            day_sh_q <= day_sh_d;
            mon_sh_q <= mon_sh_d;
            yr_sh_q  <= yr_sh_d;
            dia_q    <= dia_d;
            mes_q    <= mes_d;
            year_q   <= year_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            adout_q  <= adout_d;
            oe_q     <= oe_d;
            ad_q     <= ad_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cs_q     <= cs_d;
`ifdef BCD_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign ADout  = adout_q;
    assign bus_oe = oe_q;
    assign ad     = ad_q;
    assign wr     = wr_q;
    assign rd     = rd_q;
    assign cs     = cs_q;
    assign dia    = dia_q;
    assign mes    = mes_q;
    assign year   = year_q;
    assign busy   = busy_q;
    assign valid  = valid_q;
`ifdef BCD_CHECK_EN
    assign err    = err_q;
`endif

endmodule
